// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The state enum gives the FSM encoding that the fetch_unit localparams mirror.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // jalr targets always have bit 0 forced low
   function automatic logic [31:0] clear_bit0(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFE;
   endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: jalr / pc-relative / sequential target and misalignment detection.
// Purely combinational; the owning FSM decides when the result is committed.
module pc_next
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        pc_src0,
   input  logic        pc_src1,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   output logic [31:0] pc_plus4,
   output logic [31:0] target,
   output logic        misalign
);

   logic signed [31:0] pc_s;
   logic signed [31:0] imm_s;
   logic signed [31:0] branch_s;

   assign pc_s     = $signed(pc);
   assign imm_s    = $signed(imm_ext);
   assign branch_s = pc_s + imm_s;
   assign pc_plus4 = pc + 32'd4;

   // jalr takes priority over the pc-relative select
   always_comb begin
      target = pc_plus4;
      if (pc_src1) begin
         target = clear_bit0(alu_result);
      end else if (pc_src0) begin
         target = $unsigned(branch_s);
      end
   end

   assign misalign = target[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents each instruction for exactly one execute cycle before advancing.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src0,
   input  logic        pc_src1,
   input  logic [31:0] imm_ext,
   input  logic [31:0] alu_result,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_fault
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_FETCH = FETCH;
   localparam logic [1:0] S_EXEC  = EXEC;
   localparam logic [1:0] S_FAULT = FAULT;

   logic [1:0]  state;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        fault_q;
   logic [31:0] target;
   logic        misalign;

   pc_next u_pc_next (
      .pc         (pc_q),
      .pc_src0    (pc_src0),
      .pc_src1    (pc_src1),
      .imm_ext    (imm_ext),
      .alu_result (alu_result),
      .pc_plus4   (pc_plus4),
      .target     (target),
      .misalign   (misalign)
   );

   // ack is only looked at in FETCH; FAULT is left only through reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         fault_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (misalign) begin
                  fault_q <= 1'b1;
                  state   <= S_FAULT;
               end else begin
                  pc_q  <= target;
                  state <= S_FETCH;
               end
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = (state == S_FETCH);
   assign instr_valid = (state == S_EXEC);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed and randomized instruction streams
// checked against a per-instruction reference model of the PC rules.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        pc_src0;
   logic        pc_src1;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_fault;

   int total = 0;
   int bad   = 0;

   logic [31:0] pc_m;
   logic [31:0] instr_m;
   logic        fault_m;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .pc_src0     (pc_src0),
      .pc_src1     (pc_src1),
      .imm_ext     (imm_ext),
      .alu_result  (alu_result),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural next-PC rule, written straight from the instruction semantics
   function automatic logic [31:0] model_target(input logic [31:0] cur, input logic s0, input logic s1,
                                                input logic [31:0] imm, input logic [31:0] alu);
      if (s1) return {alu[31:1], 1'b0};
      if (s0) return cur + imm;
      return cur + 32'd4;
   endfunction

   // Drive rst low now, check the reset image, then release with a junk ack in the IDLE cycle
   task automatic apply_reset();
      rst = 1'b0;
      #1;
      pc_m    = RST_PC;
      instr_m = NOP;
      fault_m = 1'b0;
      chk("rst_pc", pc, pc_m);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
      @(negedge clk);
      rst        = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
   endtask

   // One full instruction: FETCH with 'waits' stall cycles, then the EXEC cycle
   task automatic do_instr(input int waits, input logic [31:0] rdata, input logic s0, input logic s1,
                           input logic [31:0] imm, input logic [31:0] alu);
      logic [31:0] tgt;
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, pc_m);
      chk("fetch_pc_plus4", pc_plus4, pc_m + 32'd4);
      chk("fetch_valid", 32'(instr_valid), 32'd0);
      chk("fetch_instr_hold", instr, instr_m);
      for (int i = 0; i < waits; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         pc_src0    = 1'($urandom_range(0, 1));
         pc_src1    = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, pc_m);
         chk("wait_instr", instr, instr_m);
         chk("wait_valid", 32'(instr_valid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      @(negedge clk);
      instr_m = rdata;
      chk("exec_valid", 32'(instr_valid), 32'd1);
      chk("exec_instr", instr, instr_m);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_pc", pc, pc_m);
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      pc_src0    = s0;
      pc_src1    = s1;
      imm_ext    = imm;
      alu_result = alu;
      @(negedge clk);
      imem_ack   = 1'b0;
      pc_src0    = 1'($urandom_range(0, 1));
      pc_src1    = 1'($urandom_range(0, 1));
      imm_ext    = $urandom;
      alu_result = $urandom;
      tgt = model_target(pc_m, s0, s1, imm, alu);
      if (tgt[1]) fault_m = 1'b1;
      else        pc_m = tgt;
      chk("post_fault", 32'(fetch_fault), 32'(fault_m));
      chk("post_pc", pc, pc_m);
      chk("post_valid", 32'(instr_valid), 32'd0);
      chk("post_instr_hold", instr, instr_m);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] a;
      rst        = 1'b0;
      pc_src0    = 1'b0;
      pc_src1    = 1'b0;
      imm_ext    = 32'd0;
      alu_result = 32'd0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      apply_reset();
      chk("idle_ack_ignored", instr, NOP);

      // Zero-wait sequential fetch, then a 3-cycle stall at pc=8
      do_instr(0, 32'h0010_0093, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("seq_addr_4", imem_addr, 32'h4);
      do_instr(0, 32'h0020_0113, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("seq_addr_8", imem_addr, 32'h8);
      do_instr(3, 32'h0030_0193, 1'b0, 1'b0, 32'd0, 32'd0);
      do_instr(0, 32'h0040_0213, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("seq_addr_10", imem_addr, 32'h10);

      // Branch back, jalr with bit-0 clear, both selects, then wrap past 2^32
      do_instr(0, 32'hFE00_0CE3, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
      chk("branch_addr", imem_addr, 32'h08);
      do_instr(1, 32'h0000_8067, 1'b0, 1'b1, 32'd0, 32'h41);
      chk("jalr_addr", imem_addr, 32'h40);
      do_instr(0, 32'h0000_8067, 1'b1, 1'b1, 32'h100, 32'h21);
      chk("both_sel_addr", imem_addr, 32'h20);
      do_instr(2, 32'h0000_8067, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFD);
      chk("high_addr", imem_addr, 32'hFFFF_FFFC);
      do_instr(0, 32'h0000_0013, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_no_fault", 32'(fetch_fault), 32'd0);

      // Random aligned traffic
      for (int n = 0; n < 25; n++) begin
         r = $urandom;
         a = $urandom;
         do_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r & 32'hFFFF_FFFC, a & 32'hFFFF_FFFD);
      end

      // Misaligned jalr target: sticky fault, no more requests
      a = pc_m;
      do_instr(0, 32'h0000_8067, 1'b0, 1'b1, 32'd0, 32'h102);
      chk("fault_pc_kept", pc, a);
      for (int n = 0; n < 4; n++) begin
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         @(negedge clk);
         chk("fault_req", 32'(imem_req), 32'd0);
         chk("fault_valid", 32'(instr_valid), 32'd0);
         chk("fault_sticky", 32'(fetch_fault), 32'd1);
         chk("fault_pc", pc, a);
      end
      imem_ack = 1'b0;
      apply_reset();
      chk("fault_cleared", 32'(fetch_fault), 32'd0);
      do_instr(0, 32'h1234_5013, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset in the middle of a stalled FETCH at pc=4
      imem_ack = 1'b0;
      @(negedge clk);
      chk("midfetch_req", 32'(imem_req), 32'd1);
      chk("midfetch_addr", imem_addr, 32'h4);
      apply_reset();
      chk("refetch_addr", imem_addr, RST_PC);
      chk("refetch_instr", instr, NOP);
      do_instr(1, 32'h0050_0293, 1'b0, 1'b0, 32'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
